scs8hd_busrcv_1: RTL and testbench

SCS8HD_BUSRCV_1 -- requirements
Module: scs8hd_busrcv_1

---
 rtl/scs8hd_busrcv_1.sv | 137 +++++++++++++
 tb/tb_scs8hd_busrcv_1.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/scs8hd_busrcv_1.sv
// Filtered receiver for a shared inverting-tristate bus line.
// Q keeps its last value whenever the driver is released or still settling.
module scs8hd_busrcv_1 #(
    parameter int FILT = 3,
    parameter bit INV  = 1'b1
) (
    input  logic CLK,
    input  logic RESET,
    input  logic BUS,
    input  logic TEB,
    output logic Q,
    output logic RISE,
    output logic FALL,
    output logic VALID
);

    typedef enum logic [1:0] {
        HIZ,
        SETTLE,
        ACTIVE
    } state_t;

    localparam logic       BUS_RST = INV;
    localparam logic [3:0] LAST    = 4'(FILT - 1);

    logic       bus_s1_q, bus_s2_q;
    logic       te_s1_q, te_s2_q;
    state_t     state_q, state_d;
    logic [3:0] ecnt_q, ecnt_d;
    logic [3:0] dcnt_q, dcnt_d;
    logic       q_q, q_d;
    logic       rise_q, rise_d;
    logic       fall_q, fall_d;
    logic       valid_q, valid_d;
    logic       d;
    logic       load;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            bus_s1_q <= BUS_RST;
            bus_s2_q <= BUS_RST;
            te_s1_q  <= 1'b1;
            te_s2_q  <= 1'b1;
        end else begin
            bus_s1_q <= BUS;
            bus_s2_q <= bus_s1_q;
            te_s1_q  <= TEB;
            te_s2_q  <= te_s1_q;
        end
    end

    assign d = INV ? ~bus_s2_q : bus_s2_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= HIZ;
            ecnt_q  <= 4'd0;
            dcnt_q  <= 4'd0;
            q_q     <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ecnt_q  <= ecnt_d;
            dcnt_q  <= dcnt_d;
            q_q     <= q_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ecnt_d  = ecnt_q;
        dcnt_d  = dcnt_q;
        q_d     = q_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        load    = 1'b0;
        if (te_s2_q) begin
            state_d = HIZ;
            ecnt_d  = 4'd0;
            dcnt_d  = 4'd0;
        end else begin
            unique case (state_q)
                // The HIZ->SETTLE cycle is the first settle cycle.
                HIZ: begin
                    if (FILT == 1) begin
                        state_d = ACTIVE;
                        load    = 1'b1;
                    end else begin
                        state_d = SETTLE;
                        ecnt_d  = 4'd1;
                    end
                end
                SETTLE: begin
                    if (ecnt_q == LAST) begin
                        state_d = ACTIVE;
                        ecnt_d  = 4'd0;
                        load    = 1'b1;
                    end else begin
                        ecnt_d = ecnt_q + 4'd1;
                    end
                end
                ACTIVE: begin
                    if (d == q_q) begin
                        dcnt_d = 4'd0;
                    end else if (dcnt_q == LAST) begin
                        dcnt_d = 4'd0;
                        load   = 1'b1;
                    end else begin
                        dcnt_d = dcnt_q + 4'd1;
                    end
                end
                default: begin
                    state_d = HIZ;
                    ecnt_d  = 4'd0;
                    dcnt_d  = 4'd0;
                end
            endcase
        end
        if (load) begin
            q_d    = d;
            rise_d = d & ~q_q;
            fall_d = ~d & q_q;
        end
        valid_d = (state_d == ACTIVE);
    end

    assign Q     = q_q;
    assign RISE  = rise_q;
    assign FALL  = fall_q;
    assign VALID = valid_q;

endmodule

// File: tb/tb_scs8hd_busrcv_1.sv
// Directed bench for scs8hd_busrcv_1: FILT=3 and FILT=1 instances, INV=1.
// Inputs change 1ns after a rising edge; outputs are sampled there too.
module tb_scs8hd_busrcv_1;

    logic CLK = 1'b0;
    logic RESET, BUS, TEB;
    logic Q, RISE, FALL, VALID;
    logic Q1, RISE1, FALL1, VALID1;
    int   checks = 0;
    int   failures = 0;

    scs8hd_busrcv_1 #(.FILT(3), .INV(1'b1)) dut (
        .CLK(CLK), .RESET(RESET), .BUS(BUS), .TEB(TEB),
        .Q(Q), .RISE(RISE), .FALL(FALL), .VALID(VALID)
    );

    scs8hd_busrcv_1 #(.FILT(1), .INV(1'b1)) dut1 (
        .CLK(CLK), .RESET(RESET), .BUS(BUS), .TEB(TEB),
        .Q(Q1), .RISE(RISE1), .FALL(FALL1), .VALID(VALID1)
    );

    always #5 CLK = ~CLK;

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b1; TEB = 1'b0; BUS = 1'b0;
        cyc(); cyc();
        checks++;
        if ({Q, RISE, FALL, VALID} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_state got=%b want=0000", {Q, RISE, FALL, VALID});
        end
        RESET = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            cyc();
            checks++;
            if (VALID !== (k >= 5) || Q !== (k >= 5) || RISE !== (k == 5)) begin
                failures++;
                $display("FAIL settle_k%0d got V=%b Q=%b R=%b want V=%b Q=%b R=%b",
                         k, VALID, Q, RISE, k >= 5, k >= 5, k == 5);
            end
            checks++;
            if (VALID1 !== (k >= 3) || Q1 !== (k >= 3) || RISE1 !== (k == 3)) begin
                failures++;
                $display("FAIL settle1_k%0d got V=%b Q=%b R=%b", k, VALID1, Q1, RISE1);
            end
        end
    endtask

    task automatic test_fall();
        BUS = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            cyc();
            checks++;
            if (Q !== (k < 5) || FALL !== (k == 5) || RISE !== 1'b0) begin
                failures++;
                $display("FAIL fall_k%0d got Q=%b F=%b R=%b want Q=%b F=%b R=0",
                         k, Q, FALL, RISE, k < 5, k == 5);
            end
        end
        BUS = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            cyc();
            checks++;
            if (Q !== (k >= 5) || RISE !== (k == 5) || FALL !== 1'b0) begin
                failures++;
                $display("FAIL rise_k%0d got Q=%b R=%b F=%b want Q=%b R=%b F=0",
                         k, Q, RISE, FALL, k >= 5, k == 5);
            end
        end
    endtask

    task automatic test_glitch();
        BUS = 1'b1;
        cyc();
        cyc();
        BUS = 1'b0;
        for (int k = 3; k <= 10; k++) begin
            cyc();
            checks++;
            if (Q !== 1'b1 || RISE !== 1'b0 || FALL !== 1'b0) begin
                failures++;
                $display("FAIL glitch_k%0d got Q=%b R=%b F=%b want Q=1 R=0 F=0",
                         k, Q, RISE, FALL);
            end
        end
    endtask

    task automatic test_hiz();
        TEB = 1'b1;
        BUS = 1'bx;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            if (k == 4) BUS = 1'b1;
            checks++;
            if (VALID !== (k < 3) || Q !== 1'b1 || RISE !== 1'b0 || FALL !== 1'b0) begin
                failures++;
                $display("FAIL hiz_k%0d got V=%b Q=%b R=%b F=%b want V=%b Q=1 R=0 F=0",
                         k, VALID, Q, RISE, FALL, k < 3);
            end
        end
        TEB = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            cyc();
            checks++;
            if (VALID !== (k >= 5) || Q !== (k < 5) || FALL !== (k == 5)) begin
                failures++;
                $display("FAIL reentry_k%0d got V=%b Q=%b F=%b want V=%b Q=%b F=%b",
                         k, VALID, Q, FALL, k >= 5, k < 5, k == 5);
            end
        end
    endtask

    task automatic test_te_wins();
        BUS = 1'b0;
        TEB = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            cyc();
            checks++;
            if (Q1 !== 1'b0 || RISE1 !== 1'b0 || FALL1 !== 1'b0 || VALID1 !== (k < 3)) begin
                failures++;
                $display("FAIL tewins_k%0d got Q=%b R=%b F=%b V=%b want Q=0 R=0 F=0 V=%b",
                         k, Q1, RISE1, FALL1, VALID1, k < 3);
            end
        end
    endtask

    task automatic test_filt1();
        logic exp_q, prev_q;
        TEB = 1'b0;
        BUS = 1'b1;
        for (int k = 0; k < 8; k++) cyc();
        checks++;
        if (VALID1 !== 1'b1 || Q1 !== 1'b0) begin
            failures++;
            $display("FAIL filt1_ready got V=%b Q=%b want V=1 Q=0", VALID1, Q1);
        end
        prev_q = 1'b0;
        for (int i = 0; i < 12; i++) begin
            BUS = 1'(i & 1);
            cyc();
            exp_q = (i < 2) ? 1'b0 : ~1'((i - 2) & 1);
            checks++;
            if (Q1 !== exp_q || RISE1 !== (exp_q & ~prev_q) || FALL1 !== (~exp_q & prev_q)) begin
                failures++;
                $display("FAIL filt1_t%0d got Q=%b R=%b F=%b want Q=%b R=%b F=%b",
                         i, Q1, RISE1, FALL1, exp_q, exp_q & ~prev_q, ~exp_q & prev_q);
            end
            prev_q = exp_q;
        end
    endtask

    task automatic test_reset_mid();
        BUS = 1'b0;
        TEB = 1'b0;
        for (int k = 0; k < 8; k++) cyc();
        checks++;
        if (Q !== 1'b1 || VALID !== 1'b1) begin
            failures++;
            $display("FAIL premid got Q=%b V=%b want Q=1 V=1", Q, VALID);
        end
        #2;
        RESET = 1'b1;
        #1;
        checks++;
        if ({Q, VALID, RISE, FALL} !== 4'b0000) begin
            failures++;
            $display("FAIL async_reset got=%b want=0000", {Q, VALID, RISE, FALL});
        end
        cyc();
        checks++;
        if (FALL !== 1'b0 || Q !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold got Q=%b F=%b want 0 0", Q, FALL);
        end
        RESET = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            cyc();
            checks++;
            if (VALID !== (k >= 5) || Q !== (k >= 5) || FALL !== 1'b0) begin
                failures++;
                $display("FAIL resettle_k%0d got V=%b Q=%b F=%b want V=%b Q=%b F=0",
                         k, VALID, Q, FALL, k >= 5, k >= 5);
            end
        end
    endtask

    initial begin
        RESET = 1'b1;
        BUS = 1'b0;
        TEB = 1'b1;
        test_reset();
        test_fall();
        test_glitch();
        test_hiz();
        test_te_wins();
        test_filt1();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
